mul_hilo_unit: RTL and testbench

Iterative 32x32 unsigned multiplier with the architectural Hi/Lo register pair. It sits in the EX stage directly downstream of ALU control. It consumes the decoded ALU_mul operation (funct 25, multu) and the mfhi/mflo select strobes. It returns Hi or Lo read data to the EX result mux and raises a pipeline stall while a multiply is in flight.

---
 rtl/mul_hilo_unit.sv | 90 +++++++++
 tb/tb_mul_hilo_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_hilo_unit.sv
// Iterative unsigned shift-add multiplier feeding the architectural Hi/Lo pair.
// One product bit retires per cycle; EX stalls while a dependent op waits on it.
module mul_hilo_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mul_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_rd,
  input  logic             lo_rd,
  input  logic             flush,
  output logic [WIDTH-1:0] hilo_data,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_d;
  logic [WIDTH-1:0] mplier_d;
  logic             last;

  // acc_q[WIDTH] is always zero after a shift, so adding the full register
  // is the same as adding its low WIDTH bits.
  assign sum = acc_q + {1'b0, (mplier_q[0] ? mcand_q : '0)};
  assign {acc_d, mplier_d} = {1'b0, sum, mplier_q[WIDTH-1:1]};
  assign last = (cnt_q == CNT_W'(WIDTH-1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mul_start && !flush) begin
            mcand_q  <= op_a;
            mplier_q <= op_b;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          // A squash wins even on the final iteration: Hi/Lo stay untouched.
          if (flush) begin
            state_q <= IDLE;
          end else begin
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (last) begin
              hi_q    <= acc_d[WIDTH-1:0];
              lo_q    <= mplier_d;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q == RUN);
  assign stall     = busy && (mul_start || hi_rd || lo_rd) && !flush;
  assign done      = done_q;
  assign hilo_data = hi_rd ? hi_q : (lo_rd ? lo_q : '0);

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Self-checking bench for mul_hilo_unit: directed corners plus random products
// compared against a plain 64-bit multiply.
module tb_mul_hilo_unit;

  logic        clk, rst_n;
  logic        mul_start, hi_rd, lo_rd, flush;
  logic [31:0] op_a, op_b;
  logic [31:0] hilo_data;
  logic        busy, stall, done;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi, exp_lo;

  mul_hilo_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .mul_start(mul_start), .op_a(op_a), .op_b(op_b),
    .hi_rd(hi_rd), .lo_rd(lo_rd), .flush(flush), .hilo_data(hilo_data),
    .busy(busy), .stall(stall), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive only: launch a multiply and wait (bounded) for busy to drop.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                         output int ncyc, output logic done_seen);
    op_a = a; op_b = b; mul_start = 1'b1;
    @(posedge clk); #1;
    mul_start = 1'b0;
    ncyc = 0;
    while (busy && ncyc < 40) begin
      ncyc++;
      @(posedge clk); #1;
    end
    done_seen = done;
  endtask

  task automatic set_model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    exp_hi = p[63:32];
    exp_lo = p[31:0];
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mul_start = 1'b1; hi_rd = 1'b1; lo_rd = 1'b0; flush = 1'b0;
    op_a = 32'h5; op_b = 32'h7;
    #3;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || hilo_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs busy=%b done=%b stall=%b data=%h want 0 0 0 0",
               busy, done, stall, hilo_data);
    end
    mul_start = 1'b0; hi_rd = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    exp_hi = 32'h0; exp_lo = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int n; logic d;
    run_mul(32'd3, 32'd5, n, d);
    set_model(32'd3, 32'd5);
    checks++;
    if (n !== 32) begin errors++; $display("FAIL basic_busy_cycles got %0d want 32", n); end
    checks++;
    if (d !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", d); end
    hi_rd = 1'b1; #1;
    checks++;
    if (hilo_data !== 32'h0 || stall !== 1'b0) begin
      errors++; $display("FAIL basic_mfhi got %h stall=%b want 00000000 0", hilo_data, stall);
    end
    hi_rd = 1'b0; lo_rd = 1'b1; #1;
    checks++;
    if (hilo_data !== 32'hF) begin errors++; $display("FAIL basic_mflo got %h want 0000000f", hilo_data); end
    lo_rd = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_products(input int rounds);
    logic [31:0] va [0:3];
    logic [31:0] vb [0:3];
    int n; logic d;
    va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF;
    va[1] = 32'h80000000; vb[1] = 32'h2;
    va[2] = 32'h0;        vb[2] = 32'hDEADBEEF;
    va[3] = 32'h1;        vb[3] = 32'hCAFEF00D;
    for (int i = 0; i < 4 + rounds; i++) begin
      logic [31:0] a, b;
      if (i < 4) begin a = va[i]; b = vb[i]; end
      else begin a = $urandom; b = $urandom; end
      run_mul(a, b, n, d);
      set_model(a, b);
      checks++;
      if (n !== 32 || d !== 1'b1) begin
        errors++; $display("FAIL prod_timing %h*%h cycles=%0d done=%b want 32 1", a, b, n, d);
      end
      hi_rd = 1'b1; #1;
      checks++;
      if (hilo_data !== exp_hi) begin
        errors++; $display("FAIL prod_hi %h*%h got %h want %h", a, b, hilo_data, exp_hi);
      end
      hi_rd = 1'b0; lo_rd = 1'b1; #1;
      checks++;
      if (hilo_data !== exp_lo) begin
        errors++; $display("FAIL prod_lo %h*%h got %h want %h", a, b, hilo_data, exp_lo);
      end
      lo_rd = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_read;
    int n; int bad;
    op_a = 32'h12345678; op_b = 32'h10; mul_start = 1'b1;
    @(posedge clk); #1;
    mul_start = 1'b0;
    repeat (5) @(posedge clk);
    #1; hi_rd = 1'b1; #1;
    set_model(32'h12345678, 32'h10);
    n = 5; bad = 0;
    while (busy && n < 40) begin
      if (stall !== 1'b1) bad++;
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0 || n != 32) begin
      errors++; $display("FAIL stall_hold low_cycles=%0d busy_cycles=%0d want 0 32", bad, n);
    end
    checks++;
    if (stall !== 1'b0 || hilo_data !== 32'h1) begin
      errors++; $display("FAIL stall_release stall=%b data=%h want 0 00000001", stall, hilo_data);
    end
    hi_rd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1, b1, a2, b2;
    int n; int bad;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    op_a = a1; op_b = b1; mul_start = 1'b1;
    @(posedge clk); #1;
    op_a = a2; op_b = b2;
    n = 0; bad = 0;
    while (busy && n < 40) begin
      if (stall !== 1'b1) bad++;
      n++;
      @(posedge clk); #1;
    end
    set_model(a1, b1);
    checks++;
    if (bad != 0 || n != 32 || done !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first stall_low=%0d cycles=%0d done=%b stall=%b want 0 32 1 0",
               bad, n, done, stall);
    end
    hi_rd = 1'b1; #1;
    checks++;
    if (hilo_data !== exp_hi) begin errors++; $display("FAIL b2b_first_hi got %h want %h", hilo_data, exp_hi); end
    hi_rd = 1'b0;
    @(posedge clk); #1;
    mul_start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    set_model(a2, b2);
    checks++;
    if (n != 32 || done !== 1'b1) begin
      errors++; $display("FAIL b2b_second_timing cycles=%0d done=%b want 32 1", n, done);
    end
    lo_rd = 1'b1; #1;
    checks++;
    if (hilo_data !== exp_lo) begin errors++; $display("FAIL b2b_second_lo got %h want %h", hilo_data, exp_lo); end
    lo_rd = 1'b0; hi_rd = 1'b1; #1;
    checks++;
    if (hilo_data !== exp_hi) begin errors++; $display("FAIL b2b_second_hi got %h want %h", hilo_data, exp_hi); end
    hi_rd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_flush_reset;
    int dcount;
    op_a = $urandom; op_b = $urandom; mul_start = 1'b1;
    @(posedge clk); #1;
    mul_start = 1'b0;
    repeat (10) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL flush_run busy=%b done=%b want 0 0", busy, done);
    end
    dcount = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done !== 1'b0) dcount++;
    end
    hi_rd = 1'b1; #1;
    checks++;
    if (dcount != 0 || hilo_data !== exp_hi) begin
      errors++; $display("FAIL flush_keep done_pulses=%0d hi=%h want 0 %h", dcount, hilo_data, exp_hi);
    end
    hi_rd = 1'b0; lo_rd = 1'b1; #1;
    checks++;
    if (hilo_data !== exp_lo) begin errors++; $display("FAIL flush_keep_lo got %h want %h", hilo_data, exp_lo); end
    lo_rd = 1'b0;
    mul_start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    mul_start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_block busy=%b want 0", busy); end
    op_a = 32'hFFFF0000; op_b = 32'h00FF00FF; mul_start = 1'b1;
    @(posedge clk); #1;
    mul_start = 1'b1; hi_rd = 1'b1;
    repeat (7) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall !== 1'b0 || hilo_data !== 32'h0) begin
      errors++; $display("FAIL reset_midrun busy=%b done=%b stall=%b data=%h want 0 0 0 0",
                         busy, done, stall, hilo_data);
    end
    mul_start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_hi = 32'h0; exp_lo = 32'h0;
    hi_rd = 1'b0; lo_rd = 1'b1; #1;
    checks++;
    if (hilo_data !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_midrun_lo data=%h busy=%b want 0 0", hilo_data, busy);
    end
    lo_rd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_select;
    int n; logic d;
    run_mul(32'h12345678, 32'h10, n, d);
    set_model(32'h12345678, 32'h10);
    hi_rd = 1'b1; lo_rd = 1'b1; #1;
    checks++;
    if (hilo_data !== exp_hi) begin errors++; $display("FAIL sel_priority got %h want %h", hilo_data, exp_hi); end
    hi_rd = 1'b0; lo_rd = 1'b0; #1;
    checks++;
    if (hilo_data !== 32'h0) begin errors++; $display("FAIL sel_none got %h want 0", hilo_data); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_products(8);
    test_stall_read();
    test_back_to_back();
    test_flush_reset();
    test_select();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
